// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory port arbiter: owner/state encodings,
// default widths and the bit positions of the one-hot winner vector.
package mem_arb_pkg;

  localparam int ADDR_W_DEF       = 32;
  localparam int DATA_W_DEF       = 32;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DREAD = 1'b1
  } owner_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_WAIT_RD = 1'b1
  } state_e;

  // One-hot winner vector layout
  localparam int SEL_W  = 3;
  localparam int SEL_F  = 0;
  localparam int SEL_DR = 1;
  localparam int SEL_DW = 2;

endpackage

// File: rtl/mem_arb_select.sv
// Combinational requester picker: write > data read > fetch, except that a
// starved, un-killed fetch request overrides both data requesters.
module mem_arb_select
  import mem_arb_pkg::*;
(
  input  logic             f_req,
  input  logic             dr_req,
  input  logic             dw_req,
  input  logic             kill,
  input  logic             starved,
  output logic [SEL_W-1:0] winner
);

  logic f_ok;

  assign f_ok = f_req & ~kill;

  always_comb begin
    winner = '0;
    if (f_ok && starved) begin
      winner[SEL_F] = 1'b1;
    end else if (dw_req) begin
      winner[SEL_DW] = 1'b1;
    end else if (dr_req) begin
      winner[SEL_DR] = 1'b1;
    end else if (f_ok) begin
      winner[SEL_F] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch reads, data reads and data writes,
// keeping at most one read outstanding and routing its data back to the owner.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                f_req_i,
  input  logic [ADDR_W-1:0]   f_addr_i,
  input  logic                f_kill_i,
  output logic                f_gnt_o,
  output logic                f_rvalid_o,
  input  logic                dr_req_i,
  input  logic [ADDR_W-1:0]   dr_addr_i,
  output logic                dr_gnt_o,
  output logic                dr_rvalid_o,
  input  logic                dw_req_i,
  input  logic [ADDR_W-1:0]   dw_addr_i,
  input  logic [DATA_W-1:0]   dw_wdata_i,
  input  logic [DATA_W/8-1:0] dw_wmask_i,
  output logic                dw_gnt_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  input  logic                mem_ready_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  state_e           state_reg, state_next;
  owner_e           owner_reg, owner_next;
  logic             drop_reg, drop_next;
  logic [CNT_W-1:0] starve_reg, starve_next;

  logic [SEL_W-1:0] winner;
  logic             starved;
  logic             idle;
  logic             issue;
  logic             accept;
  logic             resp;

  assign idle    = (state_reg == ST_IDLE);
  assign starved = (starve_reg == CNT_W'(STARVE_LIMIT));

  mem_arb_select u_select (
    .f_req   (f_req_i),
    .dr_req  (dr_req_i),
    .dw_req  (dw_req_i),
    .kill    (f_kill_i),
    .starved (starved),
    .winner  (winner)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg  <= ST_IDLE;
      owner_reg  <= OWN_FETCH;
      drop_reg   <= 1'b0;
      starve_reg <= '0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      drop_reg   <= drop_next;
      starve_reg <= starve_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    drop_next   = drop_reg;
    starve_next = starve_reg;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;
    f_gnt_o     = 1'b0;
    dr_gnt_o    = 1'b0;
    dw_gnt_o    = 1'b0;
    f_rvalid_o  = 1'b0;
    dr_rvalid_o = 1'b0;
    rdata_o     = '0;

    // Outputs are forced low for the whole reset pulse, not just after the edge
    issue  = ~reset_i & idle & (|winner);
    accept = issue & mem_ready_i;
    resp   = ~reset_i & ~idle & mem_rvalid_i;

    if (issue) begin
      mem_req_o = 1'b1;
      if (winner[SEL_DW]) begin
        mem_we_o    = 1'b1;
        mem_addr_o  = dw_addr_i;
        mem_wdata_o = dw_wdata_i;
        mem_wmask_o = dw_wmask_i;
      end else if (winner[SEL_DR]) begin
        mem_addr_o = dr_addr_i;
      end else begin
        mem_addr_o = f_addr_i;
      end
    end

    f_gnt_o  = accept & winner[SEL_F];
    dr_gnt_o = accept & winner[SEL_DR];
    dw_gnt_o = accept & winner[SEL_DW];

    if (resp) begin
      rdata_o     = mem_rdata_i;
      f_rvalid_o  = (owner_reg == OWN_FETCH) & ~drop_reg & ~f_kill_i;
      dr_rvalid_o = (owner_reg == OWN_DREAD);
    end

    case (state_reg)
      ST_IDLE: begin
        if (accept && !winner[SEL_DW]) begin
          state_next = ST_WAIT_RD;
          owner_next = winner[SEL_F] ? OWN_FETCH : OWN_DREAD;
          drop_next  = 1'b0;
        end
      end
      ST_WAIT_RD: begin
        if (f_kill_i && owner_reg == OWN_FETCH) begin
          drop_next = 1'b1;
        end
        if (mem_rvalid_i) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Count data grants that overtook a waiting fetch
    if (!f_req_i || f_gnt_o) begin
      starve_next = '0;
    end else if ((dw_gnt_o || dr_gnt_o) && !starved) begin
      starve_next = starve_reg + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: a transaction-level model
// predicts bus issues, grants and read responses; a monitor compares them.
module tb_mem_port_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int MW    = DW / 8;
  localparam int LIMIT = 4;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          f_req_i, f_kill_i, dr_req_i, dw_req_i;
  logic [AW-1:0] f_addr_i, dr_addr_i, dw_addr_i;
  logic [DW-1:0] dw_wdata_i, mem_rdata_i;
  logic [MW-1:0] dw_wmask_i;
  logic          mem_ready_i, mem_rvalid_i;
  logic          f_gnt_o, f_rvalid_o, dr_gnt_o, dr_rvalid_o, dw_gnt_o;
  logic [DW-1:0] rdata_o, mem_wdata_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [MW-1:0] mem_wmask_o;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .f_req_i(f_req_i), .f_addr_i(f_addr_i), .f_kill_i(f_kill_i),
    .f_gnt_o(f_gnt_o), .f_rvalid_o(f_rvalid_o),
    .dr_req_i(dr_req_i), .dr_addr_i(dr_addr_i),
    .dr_gnt_o(dr_gnt_o), .dr_rvalid_o(dr_rvalid_o),
    .dw_req_i(dw_req_i), .dw_addr_i(dw_addr_i), .dw_wdata_i(dw_wdata_i),
    .dw_wmask_i(dw_wmask_i), .dw_gnt_o(dw_gnt_o),
    .rdata_o(rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
  } bus_t;

  typedef struct packed {
    logic [1:0]    who;   // {dread, fetch}
    logic [DW-1:0] data;
  } rsp_t;

  bus_t       bus_q[$];
  logic [2:0] gnt_q[$];   // {dw, dr, f}
  rsp_t       rsp_q[$];

  int vectors = 0;
  int miscompares = 0;

  // Model: which reader owns the memory (0 none, 1 fetch, 2 dread)
  int busy = 0;
  bit dropped = 1'b0;
  int waits = 0;
  bit gf = 1'b0, gdr = 1'b0, gdw = 1'b0;

  int unsigned p_f, p_dr, p_dw, p_ready, p_rv, p_kill, p_stray;
  int rst_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model();
    int  win;
    bit  f_ok;
    gf = 1'b0; gdr = 1'b0; gdw = 1'b0;
    if (reset_i) begin
      busy = 0; dropped = 1'b0; waits = 0;
      return;
    end
    f_ok = f_req_i && !f_kill_i;
    win = 0;
    if (busy == 0) begin
      if (f_ok && waits >= LIMIT) win = 1;
      else if (dw_req_i)          win = 3;
      else if (dr_req_i)          win = 2;
      else if (f_ok)              win = 1;
    end
    if (busy != 0) begin
      if (mem_rvalid_i) begin
        if (busy == 2) rsp_q.push_back('{who: 2'b10, data: mem_rdata_i});
        else if (!dropped && !f_kill_i) rsp_q.push_back('{who: 2'b01, data: mem_rdata_i});
        busy = 0;
      end else if (busy == 1 && f_kill_i) begin
        dropped = 1'b1;
      end
    end
    if (win != 0) begin
      bus_q.push_back('{we: (win == 3),
                        addr: (win == 3) ? dw_addr_i : (win == 2) ? dr_addr_i : f_addr_i,
                        wdata: (win == 3) ? dw_wdata_i : '0,
                        wmask: (win == 3) ? dw_wmask_i : '0});
      if (mem_ready_i) begin
        gf = (win == 1); gdr = (win == 2); gdw = (win == 3);
        gnt_q.push_back({gdw, gdr, gf});
        if (win == 1) begin busy = 1; dropped = 1'b0; end
        if (win == 2) busy = 2;
      end
    end
    if (!f_req_i || gf) waits = 0;
    else if ((gdr || gdw) && waits < LIMIT) waits++;
  endtask

  task automatic step();
    @(negedge clk_i);
    if (rst_cnt > 0) begin reset_i = 1'b1; rst_cnt--; end
    else reset_i = 1'b0;
    if (gf)  f_req_i  = 1'b0;
    if (gdr) dr_req_i = 1'b0;
    if (gdw) dw_req_i = 1'b0;
    if (!f_req_i && $urandom_range(99) < p_f) begin
      f_req_i = 1'b1; f_addr_i = $urandom;
    end
    if (!dr_req_i && $urandom_range(99) < p_dr) begin
      dr_req_i = 1'b1; dr_addr_i = $urandom;
    end
    if (!dw_req_i && $urandom_range(99) < p_dw) begin
      dw_req_i = 1'b1; dw_addr_i = $urandom; dw_wdata_i = $urandom;
      dw_wmask_i = MW'($urandom_range(15));
    end
    f_kill_i     = ($urandom_range(99) < p_kill);
    mem_ready_i  = ($urandom_range(99) < p_ready);
    mem_rvalid_i = (busy != 0) ? ($urandom_range(99) < p_rv) : ($urandom_range(99) < p_stray);
    mem_rdata_i  = $urandom;
    model();
  endtask

  task automatic knobs(input int unsigned f, dr, dw, rdy, rv, kill, stray);
    p_f = f; p_dr = dr; p_dw = dw; p_ready = rdy; p_rv = rv; p_kill = kill; p_stray = stray;
  endtask

  // Monitor: pops an expectation whenever the DUT presents something
  always @(negedge clk_i) begin
    bus_t b;
    logic [2:0] g;
    rsp_t r;
    #3;
    if (reset_i) begin
      chk("reset_outputs_zero",
          {f_gnt_o, f_rvalid_o, dr_gnt_o, dr_rvalid_o, dw_gnt_o, rdata_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o}, '0);
    end else begin
      if (mem_req_o) begin
        if (bus_q.size() == 0) chk("unexpected_mem_req", 1'b1, 1'b0);
        else begin
          b = bus_q.pop_front();
          chk("mem_we", mem_we_o, b.we);
          chk("mem_addr", mem_addr_o, b.addr);
          chk("mem_wmask", mem_wmask_o, b.wmask);
          if (b.we) chk("mem_wdata", mem_wdata_o, b.wdata);
        end
      end
      if (f_gnt_o || dr_gnt_o || dw_gnt_o) begin
        if (gnt_q.size() == 0) chk("unexpected_gnt", {dw_gnt_o, dr_gnt_o, f_gnt_o}, 3'b000);
        else begin
          g = gnt_q.pop_front();
          chk("gnt_dw_dr_f", {dw_gnt_o, dr_gnt_o, f_gnt_o}, g);
        end
      end
      if (f_rvalid_o || dr_rvalid_o) begin
        if (rsp_q.size() == 0) chk("unexpected_rvalid", {dr_rvalid_o, f_rvalid_o}, 2'b00);
        else begin
          r = rsp_q.pop_front();
          chk("rvalid_dr_f", {dr_rvalid_o, f_rvalid_o}, r.who);
          chk("rdata", rdata_o, r.data);
        end
      end
    end
  end

  initial begin
    reset_i = 1'b1;
    f_req_i = 1'b0; dr_req_i = 1'b0; dw_req_i = 1'b0; f_kill_i = 1'b0;
    f_addr_i = '0; dr_addr_i = '0; dw_addr_i = '0; dw_wdata_i = '0; dw_wmask_i = '0;
    mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;

    // Reset with requests present: outputs must stay low
    knobs(100, 100, 100, 100, 0, 0, 100);
    rst_cnt = 3;
    repeat (3) step();

    knobs(60, 0, 0, 100, 50, 0, 0);           // fetch alone
    repeat (40) step();
    knobs(100, 100, 100, 100, 60, 0, 0);      // all three contending
    repeat (60) step();
    knobs(100, 100, 0, 100, 100, 0, 0);       // fetch starved by reads
    repeat (60) step();
    knobs(70, 70, 70, 20, 50, 0, 0);          // memory mostly not ready
    repeat (80) step();
    knobs(100, 30, 0, 100, 30, 40, 0);        // fetch kills
    repeat (80) step();

    // Reset while a fetch read is outstanding, then stray late data
    knobs(100, 0, 0, 100, 0, 0, 0);
    repeat (3) step();
    knobs(0, 0, 0, 100, 0, 0, 100);
    rst_cnt = 2;
    repeat (6) step();

    knobs(50, 50, 40, 75, 50, 10, 5);         // mixed traffic with occasional reset
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(299) == 0) rst_cnt = 2;
      step();
    end

    knobs(0, 0, 0, 100, 100, 0, 0);           // drain
    repeat (10) step();
    @(negedge clk_i);
    #5;
    chk("bus_q_drained", 128'(bus_q.size()), '0);
    chk("gnt_q_drained", 128'(gnt_q.size()), '0);
    chk("rsp_q_drained", 128'(rsp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
